jk_cmd_sequencer: RTL and testbench
===================================

// Module: jk_cmd_sequencer
// PURPOSE
//  Upstream driver stage for the JK flip-flop. Accepts {op, length} commands over a
//  valid/ready handshake and drives the flop's j/k inputs with op for length+1 clock
//  edges. Keeps a cycle-accurate model of the flop output, compares it with the
//  flop's q on every cycle and counts disagreements.
//  Sits between a command source (test controller / bus register) and one JK flop.
// PARAMETERS
//  LEN_W  8  width of cmd_len; max run = 2^LEN_W edges
//  ERR_W  8  width of err_cnt; saturates at 2^ERR_W-1
// PORTS
//  clk        in   1      rising-edge clock, shared with the JK flop
//  rst        in   1      synchronous, active-high reset
//  cmd_valid  in   1      command present
//  cmd_ready  out  1      sequencer can accept a command
//  cmd_op     in   2      {j,k}: 00 hold, 01 reset, 10 set, 11 toggle
//  cmd_len    in   LEN_W  op is applied for cmd_len+1 edges
//  j          out  1      registered, to flop j
//  k          out  1      registered, to flop k
//  q_fb       in   1      flop q, fed back
//  busy       out  1      high in RUN and DONE
//  done       out  1      one-cycle pulse when a command completes
//  q_model    out  1      predicted flop output
//  mismatch   out  1      sticky: q_fb != q_model on some cycle since reset
//  err_cnt    out  ERR_W  number of mismatching cycles, saturating
// BEHAVIOUR
//  Reset, sampled at the edge while rst=1, takes priority over everything:
//   - state=IDLE, j=k=0, done=0, mismatch=0, err_cnt=0, remaining=0
//   - q_model <= q_fb. This resyncs the model because the flop itself has no reset.
//   - No comparison or count takes place on a reset edge.
//  FSM (state register, all outputs registered except cmd_ready and busy):
//   IDLE: cmd_ready=1.
//    - cmd_valid & cmd_ready at an edge: j,k <= cmd_op, remaining <= cmd_len, -> RUN.
//    - Otherwise j=k=0.
//   RUN: cmd_ready=0; j,k are held.
//    - Each edge: if remaining==0 then j,k <= 00, done <= 1, -> DONE.
//    - Else remaining <= remaining-1.
//    - RUN lasts exactly cmd_len+1 cycles, so the flop samples op on cmd_len+1 edges.
//   DONE: cmd_ready=0, done=1 for this single cycle; next edge done <= 0, -> IDLE.
//  Throughput: one command per cmd_len+3 cycles (accept, RUN, DONE).
//  cmd_valid outside IDLE is ignored. The command is not latched; the source holds it.
//  Model update, every non-reset edge, applying the JK rule to the current registered j,k:
//    00 keep, 01 ->0, 10 ->1, 11 ->~q_model
//  The model changes on the same edge the flop does, so q_fb==q_model every cycle
//  when the flop is healthy.
//  Check, every non-reset edge:
//   - if q_fb != q_model: mismatch <= 1 and err_cnt <= err_cnt+1, holding at max.
//   - mismatch clears only on rst.
//  Width rules:
//   - remaining is LEN_W bits.
//   - cmd_len = 2^LEN_W-1 gives 2^LEN_W edges with no overflow.
//   - err_cnt never wraps.
//  Reset mid-RUN: command aborted, j=k=0 from the next cycle, no done pulse,
//  model resynced to q_fb.
// TESTING
//  1. rst 2 cycles, q_fb=0
//     -> j=k=0, cmd_ready=1, busy=0, done=0, err_cnt=0, mismatch=0, q_model=0.
//  2. op=10, len=0, flop attached
//     -> j=1 for exactly 1 cycle; q=q_model=1; done pulses 2 cycles after accept;
//        cmd_ready back on the next cycle.
//  3. From q=1: op=11, len=4
//     -> 5 toggles, q ends 0; RUN 5 cycles; err_cnt=0.
//     Then op=00, len=255 -> q stays 0 for 256 cycles; done after cycle 257.
//  4. cmd_valid held high through RUN with changing op
//     -> one accept only, j/k unchanged during RUN; the next accept happens in IDLE.
//  5. q_fb forced to 1 while the model is 0 for 3 cycles
//     -> err_cnt=3, mismatch=1 stays set.
//     Force for 300 cycles -> err_cnt=255 (ERR_W=8), no wrap.
//  6. rst asserted on the 3rd RUN cycle of op=11, len=9
//     -> no done pulse; j=k=0; q_model equals q_fb; err_cnt=0.

Source files
------------

// File: rtl/jk_cmd_sequencer.sv
// Command-driven j/k stimulus stage for one JK flop, with a cycle-accurate
// model of the flop output and a saturating count of cycles where q_fb disagrees.
module jk_cmd_sequencer #(
  parameter int LEN_W = 8,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             j,
  output logic             k,
  input  logic             q_fb,
  output logic             busy,
  output logic             done,
  output logic             q_model,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state;
  logic [LEN_W-1:0] remaining;

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);

  // NOTE: every register here is assigned with <= so all of them see the
  // pre-edge values of j, k and q_model, exactly like the flop does.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      remaining <= '0;
      j         <= 1'b0;
      k         <= 1'b0;
      done      <= 1'b0;
      mismatch  <= 1'b0;
      err_cnt   <= '0;
      // The flop has no reset, so the model adopts whatever it holds now.
      q_model   <= q_fb;
    end else begin
      case ({j, k})
        2'b01:   q_model <= 1'b0;
        2'b10:   q_model <= 1'b1;
        2'b11:   q_model <= ~q_model;
        default: q_model <= q_model;
      endcase

      if (q_fb != q_model) begin
        mismatch <= 1'b1;
        if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            j         <= cmd_op[1];
            k         <= cmd_op[0];
            remaining <= cmd_len;
            state     <= ST_RUN;
          end else begin
            j <= 1'b0;
            k <= 1'b0;
          end
        end
        ST_RUN: begin
          // remaining counts down from cmd_len, so RUN spans cmd_len+1 cycles.
          if (remaining == '0) begin
            j     <= 1'b0;
            k     <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            remaining <= remaining - 1'b1;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          j     <= 1'b0;
          k     <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Self-checking bench for jk_cmd_sequencer: a behavioural JK flop closes the
// loop, a command table feeds a scoreboard, and hand-written corner sequences follow.
module tb_jk_cmd_sequencer;

  localparam int LEN_W = 8;
  localparam int ERR_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [LEN_W-1:0] cmd_len;
  logic             j, k;
  logic             q_fb;
  logic             busy, done, q_model, mismatch;
  logic [ERR_W-1:0] err_cnt;

  logic q_flop    = 1'b0;
  logic force_en  = 1'b0;
  logic force_val = 1'b0;

  int nvec = 0;
  int nmis = 0;

  typedef struct {
    logic [1:0] op;
    int         len;
    logic       exp_q;
  } vec_t;

  typedef struct {
    logic [1:0] op;
    int         runs;
    logic       q;
  } exp_t;

  vec_t vecs[9];
  exp_t sb_q[$];

  always #5 clk = ~clk;

  // Behavioural JK flop without reset; unknown j/k leaves it unchanged.
  always @(posedge clk) begin
    case ({j, k})
      2'b01:   q_flop <= 1'b0;
      2'b10:   q_flop <= 1'b1;
      2'b11:   q_flop <= ~q_flop;
      default: q_flop <= q_flop;
    endcase
  end

  assign q_fb = force_en ? force_val : q_flop;

  jk_cmd_sequencer #(.LEN_W(LEN_W), .ERR_W(ERR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_len   (cmd_len),
    .j         (j),
    .k         (k),
    .q_fb      (q_fb),
    .busy      (busy),
    .done      (done),
    .q_model   (q_model),
    .mismatch  (mismatch),
    .err_cnt   (err_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Walks negedges until done; counts busy cycles and checks j/k hold op.
  task automatic wait_done(input logic [1:0] op, input bit hold_valid,
                           output int runs, output bit jk_ok, output bit timed_out);
    runs      = 0;
    jk_ok     = 1'b1;
    timed_out = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (!hold_valid) cmd_valid = 1'b0;
      if (done) begin
        timed_out = 1'b0;
        break;
      end
      if (busy) begin
        runs++;
        if ({j, k} !== op) jk_ok = 1'b0;
        if (hold_valid) begin
          cmd_op  = 2'($urandom_range(0, 3));
          cmd_len = LEN_W'($urandom_range(0, 255));
        end
      end
    end
  endtask

  task automatic run_cmd(input logic [1:0] op, input int len, input logic exp_q);
    int   runs;
    bit   jk_ok, timed_out;
    exp_t e;
    check("ready_before_cmd", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = LEN_W'(len);
    sb_q.push_back('{op: op, runs: len + 1, q: exp_q});
    wait_done(op, 1'b0, runs, jk_ok, timed_out);
    check("done_timeout", timed_out, 0);
    e = sb_q.pop_front();
    check("run_cycles", runs, e.runs);
    check("jk_held", jk_ok, 1);
    check("q_model_end", q_model, e.q);
    check("q_fb_end", q_fb, e.q);
    check("err_cnt_clean", err_cnt, 0);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("ready_after_done", cmd_ready, 1);
  endtask

  initial begin
    int  runs;
    bit  jk_ok, timed_out;
    bit  done_seen;

    // Expected final q follows the JK rule applied len+1 times, starting from q=0.
    vecs[0] = '{op: 2'b10, len: 0,   exp_q: 1'b1};
    vecs[1] = '{op: 2'b11, len: 4,   exp_q: 1'b0};
    vecs[2] = '{op: 2'b00, len: 255, exp_q: 1'b0};
    vecs[3] = '{op: 2'b10, len: 2,   exp_q: 1'b1};
    vecs[4] = '{op: 2'b01, len: 1,   exp_q: 1'b0};
    vecs[5] = '{op: 2'b11, len: 0,   exp_q: 1'b1};
    vecs[6] = '{op: 2'b11, len: 1,   exp_q: 1'b1};
    vecs[7] = '{op: 2'b00, len: 3,   exp_q: 1'b1};
    vecs[8] = '{op: 2'b01, len: 0,   exp_q: 1'b0};

    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_len   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_j", j, 0);
    check("rst_k", k, 0);
    check("rst_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_mismatch", mismatch, 0);
    check("rst_q_model", q_model, 0);

    foreach (vecs[i]) run_cmd(vecs[i].op, vecs[i].len, vecs[i].exp_q);
    check("scoreboard_empty", sb_q.size(), 0);

    // cmd_valid held through RUN with a changing op: one accept, j/k frozen.
    cmd_valid = 1'b1;
    cmd_op    = 2'b10;
    cmd_len   = 8'd3;
    wait_done(2'b10, 1'b1, runs, jk_ok, timed_out);
    check("hold_timeout", timed_out, 0);
    check("hold_runs", runs, 4);
    check("hold_jk_frozen", jk_ok, 1);
    cmd_op  = 2'b01;
    cmd_len = '0;
    @(negedge clk);
    check("hold_idle_ready", cmd_ready, 1);
    check("hold_idle_busy", busy, 0);
    wait_done(2'b01, 1'b0, runs, jk_ok, timed_out);
    check("second_timeout", timed_out, 0);
    check("second_runs", runs, 1);
    check("second_jk", jk_ok, 1);
    check("second_q_model", q_model, 0);
    @(negedge clk);

    // Force q_fb high against a model of 0.
    force_en  = 1'b1;
    force_val = 1'b1;
    repeat (3) @(negedge clk);
    force_en = 1'b0;
    check("force3_err_cnt", err_cnt, 3);
    check("force3_mismatch", mismatch, 1);
    repeat (4) @(negedge clk);
    check("sticky_err_cnt", err_cnt, 3);
    check("sticky_mismatch", mismatch, 1);
    force_en = 1'b1;
    repeat (300) @(negedge clk);
    force_en = 1'b0;
    check("sat_err_cnt", err_cnt, 255);
    check("sat_mismatch", mismatch, 1);

    // Reset during the third RUN cycle of a toggle run.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst2_err_cnt", err_cnt, 0);
    check("rst2_mismatch", mismatch, 0);
    cmd_valid = 1'b1;
    cmd_op    = 2'b11;
    cmd_len   = 8'd9;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("abort_busy_run", busy, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_jk", {j, k}, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    // Held a second cycle: the first reset edge still toggles the flop.
    @(negedge clk);
    rst = 1'b0;
    check("abort_q_model", q_model, 1);
    check("abort_q_fb", q_fb, 1);
    done_seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done) done_seen = 1'b1;
    end
    check("abort_no_done", done_seen, 0);
    check("abort_err_cnt", err_cnt, 0);
    check("abort_ready", cmd_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
